// File: rtl/div_controller_if.sv
// Handshake and datapath-strobe bundle for div_controller.
//   master : side that issues requests and owns the datapath (start, upd, dz)
//   slave  : the controller (ld, ld2, cng, busy, done, err, iter)
//   start  - request a divide
//   upd    - registered comparator result R >= D
//   dz     - divisor register equals zero
//   ld     - load D, R and clear Q
//   ld2    - comparator sample enable
//   cng    - subtract step
//   busy   - operation in progress
//   done   - one-cycle completion pulse
//   err    - divide-by-zero or iteration-limit error
//   iter   - subtractions issued in the current or last operation
interface div_controller_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             upd;
  logic             dz;
  logic             ld;
  logic             ld2;
  logic             cng;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter;

  modport master (
    output start, upd, dz,
    input  ld, ld2, cng, busy, done, err, iter
  );

  modport slave (
    input  start, upd, dz,
    output ld, ld2, cng, busy, done, err, iter
  );
endinterface

// File: rtl/div_controller.sv
// Moore FSM sequencing an 8-bit repeated-subtraction divider datapath.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - div_controller_if slave modport (start/upd/dz in,
//          ld/ld2/cng/busy/done/err/iter out)
// Parameters:
//   CNT_W    - width of the iteration counter and iter output
//   MAX_ITER - subtractions allowed before aborting with err (< 2**CNT_W)
module div_controller #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic            clk,
  input  logic            rst,
  div_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_EVAL,
    S_SUB,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] iter_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      iter_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.start) begin
        iter_q <= '0;
        err_q  <= 1'b0;
      end else if (state == S_SUB) begin
        iter_q <= iter_q + CNT_W'(1);
      end
      // ERR is only entered from CMP/EVAL, so this fires once on entry.
      if (state_nx == S_ERR) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    bus.ld   = 1'b0;
    bus.ld2  = 1'b0;
    bus.cng  = 1'b0;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        bus.ld   = 1'b1;
        state_nx = S_CMP;
      end
      S_CMP: begin
        bus.ld2  = 1'b1;
        state_nx = bus.dz ? S_ERR : S_EVAL;
      end
      S_EVAL: begin
        // Limit is checked before issuing a subtract: exactly MAX_ITER allowed.
        if (!bus.upd)                 state_nx = S_DONE;
        else if (iter_q == ITER_LIMIT) state_nx = S_ERR;
        else                          state_nx = S_SUB;
      end
      S_SUB: begin
        bus.cng  = 1'b1;
        state_nx = S_CMP;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        bus.done = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.err  = err_q;
  assign bus.iter = iter_q;

endmodule
